// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for fp_divider: operand pair in, quotient out,
// each side with its own valid/ready pair.
interface fp_divider_if #(
    parameter int floatsize = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [floatsize-1:0] dividend;
    logic [floatsize-1:0] divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [floatsize-1:0] quotient;
    logic                 div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, div_by_zero
    );
endinterface

// File: rtl/fp_divider.sv
// Sequential IEEE-754 divider: one restoring-division step per clock, truncating
// result, denormals flushed to zero, result held until the consumer takes it.
module fp_divider #(
    parameter int floatsize     = 32,
    parameter int exponentsize  = 8,
    parameter int exponent_bias = 127
) (
    input  logic        clk,
    input  logic        rst,
    fp_divider_if.slave bus
);
    localparam int sigsize  = floatsize - exponentsize - 1;
    localparam int remsize  = sigsize + 2;
    localparam int expwidth = exponentsize + 2;
    localparam int cntwidth = $clog2(sigsize + 2);

    localparam logic [floatsize-1:0] qnan =
        {1'b0, {exponentsize{1'b1}}, 1'b1, {(sigsize-1){1'b0}}};
    localparam logic signed [expwidth-1:0] exp_max  = {2'b00, {exponentsize{1'b1}}};
    localparam logic signed [expwidth-1:0] exp_zero = '0;
    localparam logic signed [expwidth-1:0] exp_one  = expwidth'(1);
    localparam logic signed [expwidth-1:0] bias_ext = expwidth'(exponent_bias);
    localparam logic [cntwidth-1:0]        cnt_init = cntwidth'(sigsize + 1);
    localparam logic [cntwidth-1:0]        cnt_one  = cntwidth'(1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALIZE,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [remsize-1:0]         rem_q, rem_d;
    logic [sigsize:0]           den_q, den_d;
    logic [remsize-1:0]         quo_q, quo_d;
    logic signed [expwidth-1:0] exp_q, exp_d;
    logic                       sign_q, sign_d;
    logic [cntwidth-1:0]        count_q, count_d;
    logic [floatsize-1:0]       quotient_q, quotient_d;
    logic                       div_by_zero_q, div_by_zero_d;

    logic                       sign_a, sign_b;
    logic [exponentsize-1:0]    exp_a, exp_b;
    logic [sigsize-1:0]         frac_a, frac_b;
    logic                       zero_a, zero_b, special_a, special_b;
    logic signed [expwidth-1:0] exp_a_ext, exp_b_ext;

    logic                       rem_ge;
    logic [remsize-2:0]         diff;
    logic [sigsize-1:0]         norm_frac;
    logic signed [expwidth-1:0] norm_exp;
    logic [floatsize-1:0]       norm_result;

    always_comb begin
        sign_a    = bus.dividend[floatsize-1];
        sign_b    = bus.divisor[floatsize-1];
        exp_a     = bus.dividend[floatsize-2 -: exponentsize];
        exp_b     = bus.divisor[floatsize-2 -: exponentsize];
        frac_a    = bus.dividend[sigsize-1:0];
        frac_b    = bus.divisor[sigsize-1:0];
        zero_a    = (exp_a == '0);
        zero_b    = (exp_b == '0);
        special_a = &exp_a;
        special_b = &exp_b;
        exp_a_ext = {2'b00, exp_a};
        exp_b_ext = {2'b00, exp_b};
    end

    // A successful subtraction always leaves rem < den, so the difference fits
    // in one bit less than rem and the top bit can be dropped before shifting.
    always_comb begin
        rem_ge = (rem_q >= {1'b0, den_q});
        diff   = rem_q[remsize-2:0] - den_q;
    end

    always_comb begin
        norm_frac   = '0;
        norm_exp    = exp_q;
        norm_result = '0;
        if (quo_q[remsize-1]) begin
            norm_frac = quo_q[remsize-2:1];
            norm_exp  = exp_q;
        end else begin
            norm_frac = quo_q[remsize-3:0];
            norm_exp  = exp_q - exp_one;
        end
        if (norm_exp <= exp_zero) begin
            norm_result = {sign_q, {(floatsize-1){1'b0}}};
        end else if (norm_exp >= exp_max) begin
            norm_result = {sign_q, {exponentsize{1'b1}}, {sigsize{1'b0}}};
        end else begin
            norm_result = {sign_q, norm_exp[exponentsize-1:0], norm_frac};
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        den_d         = den_q;
        quo_d         = quo_q;
        exp_d         = exp_q;
        sign_d        = sign_q;
        count_d       = count_q;
        quotient_d    = quotient_q;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d        = sign_a ^ sign_b;
                    div_by_zero_d = 1'b0;
                    rem_d         = {1'b0, 1'b1, frac_a};
                    den_d         = {1'b1, frac_b};
                    quo_d         = '0;
                    exp_d         = exp_a_ext - exp_b_ext + bias_ext;
                    count_d       = cnt_init;
                    if (special_a || special_b || (zero_a && zero_b)) begin
                        quotient_d = qnan;
                        state_d    = DONE;
                    end else if (zero_b) begin
                        quotient_d    = {sign_a ^ sign_b, {exponentsize{1'b1}}, {sigsize{1'b0}}};
                        div_by_zero_d = 1'b1;
                        state_d       = DONE;
                    end else if (zero_a) begin
                        quotient_d = {sign_a ^ sign_b, {(floatsize-1){1'b0}}};
                        state_d    = DONE;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end

            DIVIDE: begin
                if (rem_ge) begin
                    quo_d = {quo_q[remsize-2:0], 1'b1};
                    rem_d = {diff, 1'b0};
                end else begin
                    quo_d = {quo_q[remsize-2:0], 1'b0};
                    rem_d = {rem_q[remsize-2:0], 1'b0};
                end
                count_d = count_q - cnt_one;
                if (count_q == '0) begin
                    count_d = '0;
                    state_d = NORMALIZE;
                end
            end

            NORMALIZE: begin
                quotient_d = norm_result;
                state_d    = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            den_q         <= '0;
            quo_q         <= '0;
            exp_q         <= '0;
            sign_q        <= 1'b0;
            count_q       <= '0;
            quotient_q    <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            den_q         <= den_d;
            quo_q         <= quo_d;
            exp_q         <= exp_d;
            sign_q        <= sign_d;
            count_q       <= count_d;
            quotient_q    <= quotient_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_fp_divider.sv
// Directed-vector bench for fp_divider: hand-computed quotients, latency,
// backpressure and mid-operation reset.
module tb_fp_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fp_divider_if #(.floatsize(32)) bus ();

    fp_divider #(
        .floatsize(32),
        .exponentsize(8),
        .exponent_bias(127)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one operand pair; returns at 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency 1 means out_valid is already high in the cycle right after the accept.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic exp_dbz, input int exp_lat);
        int lat;
        applyStimulus(a, b);
        waitResult(lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_q"}, bus.quotient, exp_q);
        checkOutput({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        checkOutput({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int highs;
        logic [31:0] held;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_quotient", bus.quotient, 32'h0000_0000);
        checkOutput("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", 32'(bus.in_ready), 32'd1);

        runCase("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
        runCase("one_by_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27);
        runCase("neg_ten_by_2p5", 32'hC120_0000, 32'h4020_0000, 32'hC080_0000, 1'b0, 27);
        runCase("three_by_zero", 32'h4040_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1);
        runCase("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1);
        runCase("negzero_by_two", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1);
        runCase("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 27);
        runCase("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 27);
        runCase("inf_operand", 32'h7F80_0000, 32'h4000_0000, 32'h7FC0_0000, 1'b0, 1);
        runCase("neg_by_neg", 32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000, 1'b0, 27);

        // Backpressure: result held for 5 cycles, a new pair offered meanwhile is ignored.
        applyStimulus(32'h40C0_0000, 32'h4000_0000);
        waitResult(lat);
        checkOutput("bp_lat", 32'(lat), 32'd27);
        held = bus.quotient;
        checkOutput("bp_q", held, 32'h4040_0000);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.dividend = 32'h3F80_0000;
                bus.divisor  = 32'h4040_0000;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checkOutput("bp_hold_q", bus.quotient, 32'h4040_0000);
            checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_ignored_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_ignored_valid", 32'(bus.out_valid), 32'd0);

        // Reset at the 10th iteration aborts the operation without a result.
        applyStimulus(32'h40C0_0000, 32'h4000_0000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) highs++;
        end
        checkOutput("abort_no_valid", 32'(highs), 32'd0);
        runCase("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_divider.md
# fp_divider

Sequential IEEE-754 single-precision divider: computes `dividend / divisor` with one restoring-division iteration per clock. Accepts an operand pair over a valid/ready handshake and holds the result until the consumer takes it. It is the runtime counterpart of the constant-coefficient FP multiplier in the inference datapath, and is used for normalisation and averaging layers where the divisor is data-dependent. Results are truncated (round toward zero) and denormals are flushed, matching the multiplier's numeric behaviour.

## Interface
- `floatsize`, 32, total float width
- `exponentsize`, 8, exponent field width; significand width = floatsize-exponentsize-1
- `exponent_bias`, 127, exponent bias
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands; equals (state==IDLE)
- `dividend`  in  floatsize  numerator
- `divisor`  in  floatsize  denominator
- `out_valid`  out  1  `quotient` and `div_by_zero` valid
- `out_ready`  in  1  consumer accepts result
- `quotient`  out  floatsize  result
- `div_by_zero`  out  1  set with a result whose divisor was zero (dividend non-zero and finite)

## Operation
- States: IDLE, DIVIDE, NORMALIZE, DONE.
- IDLE: when in_valid && in_ready, latch operands and classify them. Zero = exponent field 0, which flushes denormals. Special = exponent all-ones.
  - Either operand special, or 0/0: quotient = 0x7FC00000, go to DONE.
  - Divisor zero, dividend non-zero: quotient = {sign, all-ones exp, 0}, div_by_zero=1, go to DONE.
  - Dividend zero: quotient = {sign, 0...}, go to DONE.
  - Otherwise: go to DIVIDE.
- Sign = sign_a ^ sign_b in all cases except the NaN result, which has sign 0.
- DIVIDE setup:
  - rem (significandsize+2 bits) = {0,1,frac_a}; den = {1,frac_b}.
  - Signed exponent exp = e_a - e_b + bias, computed in exponentsize+2 bits.
  - counter = significandsize+1.
- DIVIDE, each cycle:
  - If rem >= den: q = {q,1}, rem = (rem-den)<<1.
  - Else: q = {q,0}, rem = rem<<1.
  - Decrement counter. Go to NORMALIZE after significandsize+2 iterations (25 for fp32).
- NORMALIZE: q has significandsize+2 bits.
  - If q MSB = 1: frac = q[msb-1:1].
  - Else: frac = q[msb-2:0] and exp = exp-1.
  - Then: exp <= 0 gives signed zero; exp >= all-ones gives signed infinity; otherwise {sign, exp, frac}. Register the result and go to DONE.
- DONE: out_valid=1. quotient and div_by_zero stay stable until out_ready. On out_valid && out_ready go to IDLE. No same-cycle re-accept.
- Remainder bits are discarded, so the result is truncated.

## Timing
- Reset values: state IDLE, out_valid 0, quotient 0, div_by_zero 0, internal registers 0. in_ready = 1 from the first cycle after reset.
- Reset asserted in any state aborts the operation. No out_valid is produced for the aborted operation.
- Normal latency: accept at edge k; iterations on edges k+1..k+25; NORMALIZE registers the result at edge k+26. out_valid is high from the cycle after edge k+26.
- Special-case latency: out_valid is high from the cycle after the accepting edge.
- Minimum throughput: one result per 28 cycles for the normal path. in_ready returns the cycle after the output handshake.
- in_valid while busy is ignored. The operand source must hold its pair until in_ready.
- div_by_zero is cleared on every accept.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> quotient 0x40400000, div_by_zero 0, out_valid exactly 27 cycles after the accepting edge.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also 0xC1200000 / 0x40200000 -> 0xC0800000 (-4).
- 0x40400000 / 0x00000000 -> 0x7F800000 with div_by_zero=1, out_valid 1 cycle after accept. 0x00000000 / 0x00000000 -> 0x7FC00000. 0x80000000 / 0x40000000 -> 0x80000000.
- 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow). 0x00800000 / 0x7F000000 -> 0x00000000 (underflow flush).
- Backpressure: hold out_ready low 5 cycles in DONE -> quotient, out_valid and in_ready (0) stay stable. Pulse in_valid with a new pair meanwhile -> it is ignored. Release out_ready -> in_ready=1 next cycle.
- Assert rst for one cycle at iteration 10 -> out_valid never rises for that operation. in_ready=1 after reset. The next pair 6/2 returns 0x40400000.
